// File: rtl/spi_pkg.sv
// Shared definitions for the SPI core: data-path states, default transfer
// width and the pattern shifted out when the CPU has not supplied a byte.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } spi_state_e;

  localparam int SPI_WIDTH_DEF = 8;

  // Wide enough for any practical WIDTH; users truncate to their width.
  localparam logic [63:0] SPI_IDLE_FILL = '1;

endpackage

// File: rtl/spi_shifter.sv
// SPI data-path shifter: transmit buffer, shift register, received-byte
// register and write-collision flag. Strobes come from SCK control; load and
// run qualification come from the master controller.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shifter_en,
  input  logic             spdr_rd_en,
  input  logic             cpu_wr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             lsbfe,
  input  logic             sample_stb,
  input  logic             shift_stb,
  input  logic             sdi,
  input  logic             wcol_clr,
  output logic             sdo,
  output logic [WIDTH-1:0] rx_data,
  output logic             tx_empty,
  output logic             byte_done,
  output logic             wcol
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] FILL  = WIDTH'(SPI_IDLE_FILL);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             lsb_q, lsb_d;
  logic             samp_q, samp_d;
  logic             done_pend_q, done_pend_d;
  logic             byte_done_q, byte_done_d;
  logic             wcol_q, wcol_d;
  logic             shift_bit;

  // Insert one bit at the end dictated by the latched bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic b,
                                                input logic lsb_first);
    logic [WIDTH-1:0] r;
    if (lsb_first) r = {b, sr[WIDTH-1:1]};
    else           r = {sr[WIDTH-2:0], b};
    return r;
  endfunction

  // Bit currently presented on the wire for the latched bit order.
  function automatic logic out_bit(input logic [WIDTH-1:0] sr,
                                   input logic lsb_first);
    return lsb_first ? sr[0] : sr[WIDTH-1];
  endfunction

  // Next-state and data-path update for the whole shifter.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    tx_buf_d    = tx_buf_q;
    tx_valid_d  = tx_valid_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    lsb_d       = lsb_q;
    samp_d      = samp_q;
    done_pend_d = 1'b0;
    byte_done_d = done_pend_q;
    wcol_d      = wcol_q & ~wcol_clr;
    // A coincident sample makes the fresh sdi value the one shifted in.
    shift_bit   = sample_stb ? sdi : samp_q;

    case (state_q)
      ST_IDLE: begin
        if (spdr_rd_en) begin
          state_d    = ST_LOADED;
          shreg_d    = tx_valid_q ? tx_buf_q : FILL;
          tx_valid_d = 1'b0;
          bit_cnt_d  = '0;
          lsb_d      = lsbfe;
        end
      end
      ST_LOADED: begin
        if (shifter_en)       state_d = ST_ACTIVE;
        else if (!spdr_rd_en) state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!shifter_en) begin
          state_d = ST_IDLE;
        end else begin
          if (sample_stb) begin
            samp_d = sdi;
            if (bit_cnt_q < CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
          if (shift_stb) shreg_d = shift_in(shreg_q, shift_bit, lsb_q);
          // Last bit goes straight into rx_data without waiting for a shift.
          if (sample_stb && (bit_cnt_q == CNT_LAST)) begin
            rx_data_d   = shift_in(shreg_q, sdi, lsb_q);
            state_d     = ST_DONE;
            done_pend_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!shifter_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU writes land after the load so a same-cycle write stays pending.
    if (cpu_wr) begin
      if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
        tx_buf_d   = cpu_wdata;
        tx_valid_d = 1'b1;
      end else begin
        wcol_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= FILL;
      tx_buf_q    <= '0;
      tx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      lsb_q       <= 1'b0;
      samp_q      <= 1'b0;
      done_pend_q <= 1'b0;
      byte_done_q <= 1'b0;
      wcol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      tx_buf_q    <= tx_buf_d;
      tx_valid_q  <= tx_valid_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      lsb_q       <= lsb_d;
      samp_q      <= samp_d;
      done_pend_q <= done_pend_d;
      byte_done_q <= byte_done_d;
      wcol_q      <= wcol_d;
    end
  end

  assign sdo       = ((state_q == ST_LOADED) || (state_q == ST_ACTIVE))
                     ? out_bit(shreg_q, lsb_q) : 1'b1;
  assign rx_data   = rx_data_q;
  assign tx_empty  = ~tx_valid_q;
  assign byte_done = byte_done_q;
  assign wcol      = wcol_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Randomised bench for spi_shifter. The reference model works at the byte
// level: the byte expected on sdo is the pending CPU byte (or 0xFF), the
// byte expected in rx_data is the byte driven on sdi.
module tb_spi_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         shifter_en = 1'b0;
  logic         spdr_rd_en = 1'b0;
  logic         cpu_wr = 1'b0;
  logic [W-1:0] cpu_wdata = '0;
  logic         lsbfe = 1'b0;
  logic         sample_stb = 1'b0;
  logic         shift_stb = 1'b0;
  logic         sdi = 1'b0;
  logic         wcol_clr = 1'b0;
  logic         sdo;
  logic [W-1:0] rx_data;
  logic         tx_empty;
  logic         byte_done;
  logic         wcol;

  spi_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .shifter_en(shifter_en), .spdr_rd_en(spdr_rd_en),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .lsbfe(lsbfe),
    .sample_stb(sample_stb), .shift_stb(shift_stb), .sdi(sdi),
    .wcol_clr(wcol_clr), .sdo(sdo), .rx_data(rx_data), .tx_empty(tx_empty),
    .byte_done(byte_done), .wcol(wcol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int xfer_id  = 0;

  // Reference model state.
  logic         model_tx_valid = 1'b0;
  logic [W-1:0] model_tx_buf   = '0;
  logic [W-1:0] model_rx       = '0;
  logic         model_wcol     = 1'b0;

  always @(negedge clk) if (byte_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (xfer %0d)", tag, got, exp, xfer_id);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [W-1:0] d);
    cpu_wr = 1'b1;
    cpu_wdata = d;
    tick();
    cpu_wr = 1'b0;
    model_tx_buf = d;
    model_tx_valid = 1'b1;
    chk("tx_empty_wr", tx_empty, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sdo"}, sdo, 1);
    chk({tag, "_rx"}, rx_data, 0);
    chk({tag, "_tx_empty"}, tx_empty, 1);
    chk({tag, "_byte_done"}, byte_done, 0);
    chk({tag, "_wcol"}, wcol, 0);
  endtask

  // One controller-driven byte exchange. abort_at / rst_at >= W disable them.
  task automatic xfer(input logic [W-1:0] rx_byte, input bit lsb,
                      input int abort_at, input bit collide, input int rst_at);
    logic [W-1:0] tx_exp;
    int done0;
    int pos;
    bit coinc;
    tx_exp = model_tx_valid ? model_tx_buf : 8'hFF;
    model_tx_valid = 1'b0;
    done0 = done_cnt;
    xfer_id++;
    $display("xfer %0d lsb=%0d tx=%02h sdi=%02h abort_at=%0d collide=%0d rst_at=%0d",
             xfer_id, lsb, tx_exp, rx_byte, abort_at, collide, rst_at);

    lsbfe = lsb;
    spdr_rd_en = 1'b1;
    tick();
    pos = lsb ? 0 : W - 1;
    chk("sdo_load", sdo, tx_exp[pos]);
    chk("tx_empty_load", tx_empty, 1);
    spdr_rd_en = 1'b0;
    shifter_en = 1'b1;
    tick();

    for (int k = 0; k < W; k++) begin
      pos = lsb ? k : W - 1 - k;
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1;
        shifter_en = 1'b0;
        model_rx = '0;
        model_tx_valid = 1'b0;
        model_wcol = 1'b0;
        check_reset_values("rst_async");
        tick();
        check_reset_values("rst_held");
        rst = 1'b1;
        tick();
        return;
      end
      if (k == abort_at) begin
        shifter_en = 1'b0;
        tick();
        chk("sdo_abort", sdo, 1);
        tick();
        tick();
        chk("done_abort", done_cnt - done0, 0);
        chk("rx_abort", rx_data, model_rx);
        return;
      end
      repeat ($urandom_range(0, 2)) tick();
      chk("sdo_bit", sdo, tx_exp[pos]);
      if (collide && k == 3) begin
        cpu_wr = 1'b1;
        cpu_wdata = W'($urandom);
        tick();
        cpu_wr = 1'b0;
        model_wcol = 1'b1;
        chk("wcol_set", wcol, 1);
        chk("tx_empty_wcol", tx_empty, 1);
        wcol_clr = 1'b1;
        cpu_wr = 1'b1;
        cpu_wdata = W'($urandom);
        tick();
        wcol_clr = 1'b0;
        cpu_wr = 1'b0;
        chk("wcol_set_wins", wcol, 1);
        chk("tx_empty_wcol2", tx_empty, 1);
        chk("sdo_after_wcol", sdo, tx_exp[pos]);
      end
      sdi = rx_byte[pos];
      coinc = ($urandom_range(0, 3) == 0);
      if (k == W - 1) begin
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        model_rx = rx_byte;
        chk("rx_data", rx_data, model_rx);
        chk("byte_done_early", byte_done, 0);
        tick();
        chk("byte_done", byte_done, 1);
        chk("sdo_done", sdo, 1);
        // Strobes while DONE must be ignored.
        sample_stb = 1'b1;
        shift_stb = 1'b1;
        sdi = ~sdi;
        tick();
        sample_stb = 1'b0;
        shift_stb = 1'b0;
        chk("byte_done_width", byte_done, 0);
        chk("rx_hold_done", rx_data, model_rx);
      end else if (coinc) begin
        sample_stb = 1'b1;
        shift_stb = 1'b1;
        sdi = rx_byte[pos];
        tick();
        sample_stb = 1'b0;
        shift_stb = 1'b0;
        sdi = $urandom_range(0, 1);
      end else begin
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        sdi = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) tick();
        chk("sdo_hold_sample", sdo, tx_exp[pos]);
        shift_stb = 1'b1;
        tick();
        shift_stb = 1'b0;
      end
    end

    shifter_en = 1'b0;
    tick();
    chk("sdo_idle", sdo, 1);
    chk("done_count", done_cnt - done0, 1);
    chk("rx_idle", rx_data, model_rx);
    chk("tx_empty_end", tx_empty, !model_tx_valid);
    chk("wcol_end", wcol, model_wcol);
  endtask

  initial begin
    logic [W-1:0] d;
    int nw;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    tick();
    // Strobes in IDLE have no effect.
    sample_stb = 1'b1;
    shift_stb = 1'b1;
    sdi = 1'b0;
    tick();
    sample_stb = 1'b0;
    shift_stb = 1'b0;
    chk("idle_strobe_sdo", sdo, 1);
    chk("idle_strobe_rx", rx_data, 0);

    // MSB-first exchange.
    cpu_write(8'hA5);
    xfer(8'h3C, 1'b0, W, 1'b0, W);
    // LSB-first exchange.
    cpu_write(8'h01);
    xfer(8'h80, 1'b1, W, 1'b0, W);
    // Write collision during ACTIVE.
    cpu_write(W'($urandom));
    xfer(W'($urandom), 1'b0, W, 1'b1, W);
    wcol_clr = 1'b1;
    tick();
    wcol_clr = 1'b0;
    model_wcol = 1'b0;
    chk("wcol_cleared", wcol, 0);
    // Empty buffer sends the idle fill.
    xfer(W'($urandom), 1'b0, W, 1'b0, W);
    // Abort after 4 samples.
    cpu_write(W'($urandom));
    xfer(W'($urandom), 1'b0, 4, 1'b0, W);
    // LOADED discarded without run; buffer is not restored.
    cpu_write(8'h5A);
    spdr_rd_en = 1'b1;
    tick();
    spdr_rd_en = 1'b0;
    model_tx_valid = 1'b0;
    tick();
    chk("discard_sdo", sdo, 1);
    chk("discard_tx_empty", tx_empty, 1);
    xfer(W'($urandom), 1'b1, W, 1'b0, W);
    // Reset mid-byte, then a clean transfer.
    cpu_write(W'($urandom));
    xfer(W'($urandom), 1'b0, W, 1'b0, 3);
    cpu_write(W'($urandom));
    xfer(W'($urandom), 1'b0, W, 1'b0, W);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) begin
        d = W'($urandom);
        cpu_write(d);
      end
      xfer(W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? $urandom_range(1, W - 1) : W,
           ($urandom_range(0, 5) == 0), W);
      if (model_wcol) begin
        wcol_clr = 1'b1;
        tick();
        wcol_clr = 1'b0;
        model_wcol = 1'b0;
        chk("wcol_clr_rand", wcol, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
